// File: rtl/edge_binarize_pack.sv
// edge_binarize_pack
// Thresholds a Sobel gradient-magnitude stream to one bit per pixel, masks the
// border pixels produced while the 3x3 window fills, and packs the bits into
// pack_p-wide words tagged with start-of-frame and end-of-line flags.
// Row/column position is tracked locally from the accept handshake.

module edge_binarize_pack #(
    parameter int linewidth_px_p = 16,
    parameter int height_px_p    = 16,
    parameter int width_p        = 8,
    parameter int pack_p         = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*width_p-1:0]   data_i,
    input  logic [2*width_p-1:0]   threshold_i,
    input  logic                   clear_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [pack_p-1:0]      data_o,
    output logic                   sof_o,
    output logic                   eol_o
);

    localparam int col_w  = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
    localparam int row_w  = (height_px_p > 1) ? $clog2(height_px_p) : 1;
    localparam int pack_w = $clog2(pack_p);

    localparam logic [col_w-1:0] col_last_c  = col_w'(linewidth_px_p - 1);
    localparam logic [row_w-1:0] row_last_c  = row_w'(height_px_p - 1);
    localparam logic [col_w-1:0] col_sof_c   = col_w'(pack_p - 1);
    localparam logic [col_w-1:0] col_inner_c = col_w'(2);
    localparam logic [row_w-1:0] row_inner_c = row_w'(2);

    logic [col_w-1:0]  col;
    logic [row_w-1:0]  row;
    logic [pack_p-1:0] partial;
    logic [pack_p-1:0] word_next;
    logic [pack_w-1:0] bit_idx;
    logic              word_last;
    logic              border;
    logic              edge_bit;
    logic              acc;
    logic              load_word;

    // The bit position inside the word is simply the low bits of the column,
    // because every line is a whole number of words.
    assign bit_idx   = col[pack_w-1:0];
    assign word_last = &bit_idx;

    // Only a pixel that completes a word needs the output register, so only
    // that pixel can be held off by a full, unconsumed output word.
    assign ready_o   = ~valid_o | ready_i | ~word_last;
    assign acc       = valid_i & ready_o;
    assign load_word = acc & ~clear_i & word_last;

    assign border    = (row < row_inner_c) | (col < col_inner_c);
    assign edge_bit  = (data_i > threshold_i) & ~border;

    // Partial word with the current pixel's bit merged in at its column slot.
    always_comb begin
        word_next          = partial;
        word_next[bit_idx] = edge_bit;
    end

    // Frame position and partial word; a clear restarts the frame and drops
    // any pixel accepted in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            col     <= '0;
            row     <= '0;
            partial <= '0;
        end else if (clear_i) begin
            col     <= '0;
            row     <= '0;
            partial <= '0;
        end else if (acc) begin
            partial <= word_last ? '0 : word_next;
            if (col == col_last_c) begin
                col <= '0;
                row <= (row == row_last_c) ? '0 : row + row_w'(1);
            end else begin
                col <= col + col_w'(1);
            end
        end
    end

    // Output word register: loads a completed word (replacing one being popped
    // in the same cycle), otherwise empties when the consumer takes it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sof_o   <= 1'b0;
            eol_o   <= 1'b0;
        end else if (load_word) begin
            valid_o <= 1'b1;
            data_o  <= word_next;
            sof_o   <= (row == '0) & (col == col_sof_c);
            eol_o   <= (col == col_last_c);
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_binarize_pack.sv
// Directed self-checking bench for edge_binarize_pack with a 16x4 frame,
// 8-bit pixels packed eight to a word.

module tb_edge_binarize_pack;

    localparam int lw_c = 16;
    localparam int ht_c = 4;
    localparam int wp_c = 8;
    localparam int pk_c = 8;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            valid_i;
    logic            ready_o;
    logic [15:0]     data_i;
    logic [15:0]     threshold_i;
    logic            clear_i;
    logic            valid_o;
    logic            ready_i;
    logic [7:0]      data_o;
    logic            sof_o;
    logic            eol_o;

    logic [9:0]      word_q[$];
    logic [7:0]      frame_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00,
                                       8'hFC, 8'hFF, 8'hFC, 8'hFF};
    int              check_count = 0;
    int              error_count = 0;
    int              acc_count   = 0;
    logic            last_acc;

    edge_binarize_pack #(
        .linewidth_px_p (lw_c),
        .height_px_p    (ht_c),
        .width_p        (wp_c),
        .pack_p         (pk_c)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .threshold_i (threshold_i),
        .clear_i     (clear_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o)
    );

    // Free-running 100 MHz clock.
    always #5 clk_i = ~clk_i;

    // Hard stop in case something upstream of the bounded waits goes wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; at mid-cycle note acceptance and log any word
    // that the consumer pops on the coming edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [15:0] t,
                                 input logic r, input logic c);
        valid_i     = v;
        data_i      = d;
        threshold_i = t;
        ready_i     = r;
        clear_i     = c;
        @(negedge clk_i);
        last_acc = v & ready_o & ~c;
        if (last_acc) acc_count++;
        if (valid_o && ready_i) word_q.push_back({sof_o, eol_o, data_o});
        @(posedge clk_i);
        #1;
    endtask

    task automatic sendPixel(input logic [15:0] d, input logic [15:0] t, input logic r);
        int n;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            applyStimulus(1'b1, d, t, r, 1'b0);
            n++;
        end
        if (!last_acc) checkOutput("pixel_accept_timeout", {31'd0, last_acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        reset_ni    = 1'b0;
        valid_i     = 1'b0;
        data_i      = '0;
        threshold_i = '0;
        clear_i     = 1'b0;
        ready_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        word_q.delete();
        acc_count = 0;
    endtask

    initial begin
        logic [9:0] e;

        // Reset state
        doReset();
        checkOutput("rst_valid_o", {31'd0, valid_o}, 32'd0);
        checkOutput("rst_data_o", {24'd0, data_o}, 32'd0);
        checkOutput("rst_sof_o", {31'd0, sof_o}, 32'd0);
        checkOutput("rst_eol_o", {31'd0, eol_o}, 32'd0);
        checkOutput("rst_ready_o", {31'd0, ready_o}, 32'd1);

        // Reset mid-frame: hold word 0, take 5 pixels of word 1, reset between edges
        for (int i = 0; i < 13; i++) sendPixel(16'hFFFF, 16'h0, 1'b0);
        checkOutput("midrst_held_valid", {31'd0, valid_o}, 32'd1);
        #3;
        reset_ni = 1'b0;
        #1;
        checkOutput("midrst_async_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("midrst_async_sof", {31'd0, sof_o}, 32'd0);
        checkOutput("midrst_async_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        for (int i = 0; i < 7; i++) sendPixel(16'hFFFF, 16'h0, 1'b1);
        checkOutput("midrst_no_word_7px", {31'd0, valid_o}, 32'd0);
        sendPixel(16'hFFFF, 16'h0, 1'b1);
        checkOutput("midrst_word_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("midrst_word_sof", {31'd0, sof_o}, 32'd1);
        checkOutput("midrst_word_eol", {31'd0, eol_o}, 32'd0);

        // Border masking over one full frame
        doReset();
        for (int i = 0; i < 64; i++) sendPixel(16'hFFFF, 16'h0, 1'b1);
        idle(2);
        checkOutput("border_word_count", word_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            e = {(i == 0), (i % 2 == 1), frame_exp[i]};
            checkOutput($sformatf("border_word%0d", i), {22'd0, word_q[i]}, {22'd0, e});
        end

        // Threshold strictness on row 2, cols 8..15
        doReset();
        for (int i = 0; i < 40; i++) sendPixel(16'h0, 16'h0, 1'b1);
        for (int c = 8; c < 16; c++)
            sendPixel((c % 2 == 1) ? 16'd101 : 16'd100, 16'd100, 1'b1);
        idle(2);
        checkOutput("thr_word_count", word_q.size(), 32'd6);
        checkOutput("thr_word_row2_lo", {22'd0, word_q[4]}, {22'd0, 10'h000});
        checkOutput("thr_word_row2_hi", {22'd0, word_q[5]}, {22'd0, 2'b01, 8'hAA});

        // Backpressure: consumer stalled for 20 cycles
        doReset();
        repeat (20) applyStimulus(1'b1, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        checkOutput("bp_accepted", acc_count, 32'd15);
        checkOutput("bp_valid_held", {31'd0, valid_o}, 32'd1);
        checkOutput("bp_ready_stall", {31'd0, ready_o}, 32'd0);
        checkOutput("bp_sof_held", {31'd0, sof_o}, 32'd1);
        checkOutput("bp_eol_held", {31'd0, eol_o}, 32'd0);
        applyStimulus(1'b1, 16'hFFFF, 16'h0, 1'b1, 1'b0);
        checkOutput("bp_swap_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("bp_swap_sof", {31'd0, sof_o}, 32'd0);
        checkOutput("bp_swap_eol", {31'd0, eol_o}, 32'd1);
        checkOutput("bp_swap_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("bp_pop_count", word_q.size(), 32'd1);
        checkOutput("bp_popped_word", {22'd0, word_q[0]}, {22'd0, 2'b10, 8'h00});

        // Frame wrap: two frames back to back
        doReset();
        for (int i = 0; i < 128; i++) sendPixel(16'hFFFF, 16'h0, 1'b1);
        idle(2);
        checkOutput("wrap_word_count", word_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            e = {(i % 8 == 0), (i % 2 == 1), frame_exp[i % 8]};
            checkOutput($sformatf("wrap_word%0d", i), {22'd0, word_q[i]}, {22'd0, e});
        end

        // clear_i with a word held in the output register
        doReset();
        for (int i = 0; i < 32; i++) sendPixel(16'hFFFF, 16'h0, 1'b1);
        idle(1);
        for (int i = 0; i < 8; i++) sendPixel(16'hFFFF, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) sendPixel(16'hFFFF, 16'h0, 1'b0);
        acc_count = 0;
        applyStimulus(1'b1, 16'hFFFF, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_pixel_dropped", acc_count, 32'd0);
        checkOutput("clr_held_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("clr_held_data", {24'd0, data_o}, 32'hFC);
        checkOutput("clr_held_sof", {31'd0, sof_o}, 32'd0);
        checkOutput("clr_held_eol", {31'd0, eol_o}, 32'd0);
        for (int i = 0; i < 8; i++) sendPixel(16'hFFFF, 16'h0, 1'b1);
        checkOutput("clr_new_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("clr_new_sof", {31'd0, sof_o}, 32'd1);
        checkOutput("clr_new_eol", {31'd0, eol_o}, 32'd0);
        checkOutput("clr_pop_count", word_q.size(), 32'd5);
        checkOutput("clr_popped_held", {22'd0, word_q[4]}, {22'd0, 2'b00, 8'hFC});

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/edge_binarize_pack.md
# edge_binarize_pack

Downstream stage of the Sobel filter: consumes the gradient-magnitude stream (abs mode), thresholds each pixel to one bit and zeroes the invalid border pixels produced while the 3x3 window fills. Packs bits into fixed-width words, tagged with start-of-frame and end-of-line flags, for the frame buffer / ESP transfer path. It tracks row and column position itself, so the producer needs no side-band position signals.

## Interface
- linewidth_px_p, 16: pixels per line; must be a multiple of pack_p.
- height_px_p, 16: lines per frame; must be ≥ 3.
- width_p, 8: source pixel width; input magnitude is 2*width_p bits.
- pack_p, 8: pixels (bits) per output word; power of two, ≥ 2.
- clk_i  in  1  single clock; all state on rising edge.
- reset_ni  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  block accepts input this cycle.
- data_i  in  2*width_p  unsigned gradient magnitude.
- threshold_i  in  2*width_p  unsigned threshold, sampled on each accepted pixel.
- clear_i  in  1  synchronous restart of frame position and partial word.
- valid_o  out  1  output word valid.
- ready_i  in  1  consumer accepts output.
- data_o  out  pack_p  packed edge bits; bit k = pixel at column (word_base + k).
- sof_o  out  1  word is first of frame (row 0, columns 0..pack_p-1).
- eol_o  out  1  word is last of its line.

## Operation
- Accept: acc = valid_i & ready_o.
- Position counters col (0..linewidth_px_p-1) and row (0..height_px_p-1) give the coordinates of the pixel being accepted. They advance on acc only. col wraps to 0 at linewidth_px_p-1 and increments row. row wraps to 0 after the last pixel of the frame.
- Border: pixel is border if row < 2 or col < 2 (window not yet full).
- Edge bit = (data_i > threshold_i, strict unsigned compare) & ~border.
- Shift/pack register: the edge bit is written at index col mod pack_p. A bit counter equals col mod pack_p, so no separate counter is needed.
- On acc with col mod pack_p = pack_p-1, the completed word is loaded into the output register with its flags:
  - sof = (row==0 & col==pack_p-1)
  - eol = (col==linewidth_px_p-1)
  - valid_o is set.
- The partial register is cleared after a word completes.
- Output register: held stable while valid_o & ~ready_i. valid_o clears on ready_i unless a new word loads in the same cycle.
- ready_o = ~valid_o | ready_i | (col mod pack_p != pack_p-1). Only word-completing pixels can stall.
- clear_i:
  - Zeroes col, row and the partial word next edge.
  - Does not affect an output word already held (valid_o, data_o, flags unchanged).
  - clear_i concurrent with acc: the clear wins and the pixel is dropped.

## Timing
- Reset (reset_ni low, asynchronous): valid_o=0, data_o=0, sof_o=0, eol_o=0, col=0, row=0, partial word=0. ready_o=1 as a consequence.
- Deassertion of reset_ni is synchronised externally; the first edge after release may accept.
- Latency: the word is visible on data_o/valid_o on the cycle after the edge accepting its last pixel.
- Throughput: one pixel per cycle; one word per pack_p cycles sustained with ready_i=1.
- Full output register (valid_o=1, ready_i=0):
  - Non-completing pixels are still accepted.
  - A completing pixel stalls (ready_o=0) until ready_i.
- Simultaneous pop and load: when ready_i=1 and a word completes in the same cycle, the new word replaces the old one and valid_o stays 1 with no bubble.
- valid_o, data_o and flags change only on pop/load; they never change while stalled.
- threshold_i may change every cycle; only the value at acceptance matters.

## Test plan
Bench parameters: linewidth_px_p=16, height_px_p=4, pack_p=8, width_p=8.

- Reset mid-frame: accept 5 pixels, pulse reset_ni low asynchronously (between edges) -> outputs 0 immediately, ready_o=1. The next 8 accepted pixels produce a sof_o=1 word.
- Border masking: all 64 pixels data_i=16'hFFFF, threshold_i=0, ready_i=1 -> words per line are:
  - rows 0–1: 8'h00, 8'h00
  - rows 2–3: 8'hFC, 8'hFF
  
  eol_o=1 on every second word; sof_o=1 only on word 0.
- Threshold strictness: row 2, cols 8..15 with data_i = threshold_i = 100 for even cols and 101 for odd cols -> word 8'hAA.
- Backpressure: ready_i=0 for 20 cycles with valid_i=1 -> first word valid. The 8th pixel of the next word sees ready_o=0 and the held data_o is stable. ready_i=1 for one cycle -> pop and load in the same cycle, valid_o remains 1.
- Frame wrap: feed 2 full frames back-to-back -> sof_o asserted on words 0 and 8 only, 16 words total, identical content.
- clear_i: accept 3 pixels, assert clear_i with valid_i=1 -> that pixel is dropped. The next word starts at col 0 with sof_o=1, and the held output is unchanged.
